// File: rtl/scan_chain_ctrl.sv
// Scan chain test controller: shifts a pattern into an SDFF chain, pulses one capture,
// unloads the response and compares it. Optional serial MISR over SO when SCAN_CTRL_MISR_EN is defined.
//
// state       | meaning
// ------------+-----------------------------------------------------
// S_IDLE      | waiting for START; SE=0, SI=0
// S_SHIFT_IN  | SE=1, SI walks PAT bits 0..CHAIN_LEN-1
// S_CAPTURE   | single functional capture cycle, SE=0, SI=0
// S_SHIFT_OUT | SE=1, SI=0, SO bits collected into CAP[0..CHAIN_LEN-1]
// S_CMP       | DONE pulse, PASS updated from CAP vs expected
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = 6
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT,
  input  logic [CHAIN_LEN-1:0] EXP,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic [CHAIN_LEN-1:0] CAP
`ifdef SCAN_CTRL_MISR_EN
  ,
  output logic [15:0]          SIG
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_CAPTURE,
    S_SHIFT_OUT,
    S_CMP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] cap_q, cap_d;
  logic                 pass_q, pass_d;
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    exp_d   = exp_q;
    cap_d   = cap_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          pat_d   = PAT;
          exp_d   = EXP;
          cnt_d   = '0;
          cap_d   = '0;
          pass_d  = 1'b0;
          state_d = S_SHIFT_IN;
        end
      end
      S_SHIFT_IN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        cnt_d   = '0;
        state_d = S_SHIFT_OUT;
      end
      S_SHIFT_OUT: begin
        for (int i = 0; i < CHAIN_LEN; i++) begin
          if (cnt_q == CNT_W'(i)) cap_d[i] = SO;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_CMP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CMP: begin
        pass_d  = (cap_q == exp_q);
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Pin drivers are computed from the next state so the flops line up with the state cycle.
    se_d = (state_d == S_SHIFT_IN) || (state_d == S_SHIFT_OUT);
    si_d = 1'b0;
    if (state_d == S_SHIFT_IN) begin
      for (int i = 0; i < CHAIN_LEN; i++) begin
        if (cnt_d == CNT_W'(i)) si_d = pat_d[i];
      end
    end
    done_d = (state_d == S_CMP);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      exp_q   <= '0;
      cap_q   <= '0;
      pass_q  <= 1'b0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      exp_q   <= exp_d;
      cap_q   <= cap_d;
      pass_q  <= pass_d;
      se_q    <= se_d;
      si_q    <= si_d;
      done_q  <= done_d;
    end
  end

  assign SE   = se_q;
  assign SI   = si_q;
  assign DONE = done_q;
  assign PASS = pass_q;
  assign CAP  = cap_q;
  assign BUSY = (state_q != S_IDLE);

`ifdef SCAN_CTRL_MISR_EN
  logic [15:0] sig_q, sig_d;

  // Serial MISR, polynomial x^16+x^12+x^5+1 (taps 16'h1021).
  always_comb begin
    sig_d = sig_q;
    if (state_q == S_IDLE && START) begin
      sig_d = 16'hFFFF;
    end else if (state_q == S_SHIFT_OUT) begin
      sig_d = {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ SO) ? 16'h1021 : 16'h0000);
    end
  end

  always_ff @(posedge CK) begin
    if (RST) sig_q <= 16'h0000;
    else     sig_q <= sig_d;
  end

  assign SIG = sig_q;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Scoreboard bench for scan_chain_ctrl with an identity-capture 16-cell SDFF chain model.
// Define SCAN_CTRL_MISR_EN to also check the SIG output.
module tb_scan_chain_ctrl;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [15:0] PAT = '0;
  logic [15:0] EXP = '0;
  logic        SO;
  logic        SE, SI, BUSY, DONE, PASS;
  logic [15:0] CAP;
`ifdef SCAN_CTRL_MISR_EN
  logic [15:0] SIG;
`endif

  scan_chain_ctrl #(.CHAIN_LEN(16), .CNT_W(6)) dut (
    .CK(CK), .RST(RST), .START(START), .PAT(PAT), .EXP(EXP), .SO(SO),
    .SE(SE), .SI(SI), .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .CAP(CAP)
`ifdef SCAN_CTRL_MISR_EN
    , .SIG(SIG)
`endif
  );

  always #5 CK = ~CK;

  // Chain model: shift when SE=1, capture its own contents (hold) when SE=0.
  logic [15:0] chain = '0;
  always @(posedge CK) if (SE) chain <= {chain[14:0], SI};
  assign SO = chain[15];

  int edge_cnt = 0;
  always @(posedge CK) edge_cnt++;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] cap;
    logic        pass;
    int          done_edge;
    logic [15:0] sig;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [15:0] misr_ref(input logic [15:0] bits);
    logic [15:0] s;
    logic        fb;
    s = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      fb = s[15] ^ bits[i];
      s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return s;
  endfunction

  // Monitor: DONE presents a result; CAP/PASS are read one cycle later once PASS has settled.
  always @(negedge CK) begin
    if (DONE) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 edge=%0d", edge_cnt);
      end else begin
        cur = sb.pop_front();
        chk("done_cycle", edge_cnt, cur.done_edge);
        @(negedge CK);
        chk("cap", {16'h0, CAP}, {16'h0, cur.cap});
        chk("pass", {31'h0, PASS}, {31'h0, cur.pass});
        chk("done_width", {31'h0, DONE}, 32'h0);
`ifdef SCAN_CTRL_MISR_EN
        chk("sig", {16'h0, SIG}, {16'h0, cur.sig});
`endif
      end
    end
  end

  // Drives one START pulse; when push is set, queues the hand-computed result.
  task automatic start_test(input logic [15:0] p, input logic [15:0] e,
                            input bit push, input logic [15:0] cap_e, input logic pass_e);
    exp_t x;
    PAT   = p;
    EXP   = e;
    START = 1'b1;
    x.cap       = cap_e;
    x.pass      = pass_e;
    x.done_edge = edge_cnt + 1 + 33;
    x.sig       = misr_ref(cap_e);
    if (push) sb.push_back(x);
    @(negedge CK);
    START = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++) @(negedge CK);
    chk("drain_timeout", sb.size(), 0);
    repeat (3) @(negedge CK);
  endtask

  logic [15:0] pat_v;
  logic        se_e, si_e;

  initial begin
    repeat (3) @(negedge CK);
    chk("rst_se",   {31'h0, SE},   32'h0);
    chk("rst_si",   {31'h0, SI},   32'h0);
    chk("rst_busy", {31'h0, BUSY}, 32'h0);
    chk("rst_done", {31'h0, DONE}, 32'h0);
    chk("rst_pass", {31'h0, PASS}, 32'h0);
    chk("rst_cap",  {16'h0, CAP},  32'h0);
    RST = 1'b0;
    @(negedge CK);

    // Pass case with full SE/SI waveform check, cycles 1..33.
    pat_v = 16'hA5C3;
    start_test(pat_v, 16'hA5C3, 1'b1, 16'hA5C3, 1'b1);
    for (int c = 1; c <= 33; c++) begin
      se_e = (c <= 16) || (c >= 18);
      si_e = (c <= 16) ? pat_v[c-1] : 1'b0;
      chk($sformatf("se_c%0d", c), {31'h0, SE}, {31'h0, se_e});
      chk($sformatf("si_c%0d", c), {31'h0, SI}, {31'h0, si_e});
      if (c == 17) chk("busy_capture", {31'h0, BUSY}, 32'h1);
      @(negedge CK);
    end
    wait_drain(100);
    chk("idle_busy", {31'h0, BUSY}, 32'h0);

    // Mismatch.
    start_test(16'hA5C3, 16'hA5C2, 1'b1, 16'hA5C3, 1'b0);
    wait_drain(100);

    // START while busy at cycle 10 must be ignored.
    start_test(16'hA5C3, 16'hA5C3, 1'b1, 16'hA5C3, 1'b1);
    repeat (9) @(negedge CK);
    PAT   = 16'hFFFF;
    EXP   = 16'hFFFF;
    START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    wait_drain(100);
    repeat (40) @(negedge CK);

    // Reset mid-shift at cycle 8: aborted test, no DONE.
    start_test(16'h5A5A, 16'h5A5A, 1'b0, 16'h0, 1'b0);
    repeat (7) @(negedge CK);
    RST = 1'b1;
    @(negedge CK);
    RST = 1'b0;
    chk("midrst_se",   {31'h0, SE},   32'h0);
    chk("midrst_si",   {31'h0, SI},   32'h0);
    chk("midrst_busy", {31'h0, BUSY}, 32'h0);
    chk("midrst_pass", {31'h0, PASS}, 32'h0);
    chk("midrst_cap",  {16'h0, CAP},  32'h0);
    chk("midrst_done", {31'h0, DONE}, 32'h0);
    repeat (40) @(negedge CK);
    start_test(16'h0001, 16'h0001, 1'b1, 16'h0001, 1'b1);
    wait_drain(100);

    // Back-to-back with START held: DONE at cycles 34 and 69.
    PAT   = 16'hFFFF;
    EXP   = 16'hFFFF;
    START = 1'b1;
    cur.cap = 16'hFFFF; cur.pass = 1'b1; cur.sig = misr_ref(16'hFFFF);
    cur.done_edge = edge_cnt + 1 + 33;
    sb.push_back(cur);
    cur.done_edge = edge_cnt + 1 + 68;
    sb.push_back(cur);
    repeat (40) @(negedge CK);
    START = 1'b0;
    wait_drain(100);

    // All-zero pattern (MISR reference case when SIG is present).
    start_test(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1);
    wait_drain(100);
`ifdef SCAN_CTRL_MISR_EN
    chk("sig_held", {16'h0, SIG}, {16'h0, misr_ref(16'h0000)});
`endif

    repeat (40) @(negedge CK);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/scan_chain_ctrl.md
SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 16: number of scan cells in the attached SDFF chain (legal range 2..64).
REQ-002 The block SHALL have parameter CNT_W, default 6: bit count width, with 2**CNT_W > CHAIN_LEN.
REQ-003 The block SHALL have port CK, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port START, input, 1 bit: a level sampled in IDLE that starts one test.
REQ-006 The block SHALL have port PAT, input, CHAIN_LEN bits: stimulus pattern, latched at START.
REQ-007 The block SHALL have port EXP, input, CHAIN_LEN bits: expected response, latched at START.
REQ-008 The block SHALL have port SO, input, 1 bit: scan-out of the last chain cell (Q of final SDFF).
REQ-009 The block SHALL have port SE, output, 1 bit: scan enable to every SDFF SE pin.
REQ-010 The block SHALL have port SI, output, 1 bit: scan-in to the first SDFF SI pin.
REQ-011 The block SHALL have port BUSY, output, 1 bit: high in any state except IDLE.
REQ-012 The block SHALL have port DONE, output, 1 bit: one-cycle pulse at test completion.
REQ-013 The block SHALL have port PASS, output, 1 bit: compare result, held until the next accepted START.
REQ-014 The block SHALL have port CAP, output, CHAIN_LEN bits: unloaded response, held until the next accepted START.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, CMP, all registered.
REQ-016 In IDLE with START=1, the block SHALL latch PAT/EXP, clear the bit counter, clear PASS and CAP, and go to SHIFT_IN.
REQ-017 In SHIFT_IN, SE SHALL be 1 and SI SHALL be PAT_latched[cnt], with cnt running 0..CHAIN_LEN-1, exactly CHAIN_LEN cycles.
REQ-018 CAPTURE SHALL last exactly one cycle with SE=0 and SI=0, so the chain captures functional data.
REQ-019 In SHIFT_OUT, SE SHALL be 1 and SI SHALL be 0 for CHAIN_LEN cycles; on each rising CK the block SHALL set CAP[cnt] <= SO, with cnt 0..CHAIN_LEN-1.
REQ-020 CMP SHALL last one cycle: PASS <= (CAP == EXP_latched), DONE=1, next state IDLE.
REQ-021 Latency SHALL be fixed: START sampled at edge 0 gives DONE high during cycle 2*CHAIN_LEN+2 (cycle 34 for CHAIN_LEN=16).
REQ-022 START while BUSY=1 SHALL be ignored, with no queuing; PAT/EXP changes while busy SHALL have no effect.
REQ-023 START held high continuously SHALL start a new test in the cycle after CMP returns to IDLE.
REQ-024 The counter SHALL wrap to 0 on each phase exit, and SHALL never index beyond CHAIN_LEN-1.
REQ-025 SE and SI SHALL be driven directly from flops (glitch-free), with no combinational path from inputs.
REQ-026 In IDLE, SE=0 and SI=0.

Reset
REQ-027 With RST=1 at a rising CK, the block SHALL set state=IDLE, SE=0, SI=0, BUSY=0, DONE=0, PASS=0, CAP=0, and counter=0.
REQ-028 RST in any state, including mid-shift, SHALL abort the test with no DONE pulse; the chain contents are don't-care.
REQ-029 RST SHALL have priority over START in the same cycle.

Configuration
REQ-030 With macro SCAN_CTRL_MISR_EN defined, the block SHALL add output SIG, 16 bits: a serial MISR over SO.
  - Polynomial x^16+x^12+x^5+1.
  - Seeded to 16'hFFFF at accepted START.
  - Updated on each SHIFT_OUT edge.
  - Held after CMP.
  - Reset value 16'h0000.
REQ-031 Without SCAN_CTRL_MISR_EN, SIG and the MISR logic SHALL be absent, with all other behaviour identical.

Verification
The bench uses a 16-cell SDFF-style shift chain model whose capture loads its own current contents (identity), so CAP equals PAT.
REQ-032 The bench SHALL cover a pass case: PAT=16'hA5C3, EXP=16'hA5C3, pulse START.
  - SE=1 for cycles 1-16, SE=0 at cycle 17, SE=1 for cycles 18-33.
  - DONE at cycle 34, CAP=16'hA5C3, PASS=1.
REQ-033 The bench SHALL cover a mismatch: PAT=16'hA5C3, EXP=16'hA5C2 -> DONE at cycle 34, CAP=16'hA5C3, PASS=0.
REQ-034 The bench SHALL cover START while busy: START pulse at cycle 10 with PAT=16'hFFFF -> ignored; CAP=16'hA5C3 and exactly one DONE.
REQ-035 The bench SHALL cover reset mid-operation: RST at cycle 8.
  - Next cycle: SE=0, BUSY=0, PASS=0, CAP=0, no DONE.
  - A new START with PAT=EXP=16'h0001 then gives PASS=1.
REQ-036 The bench SHALL cover back-to-back tests: START held high with PAT=EXP=16'hFFFF -> DONE pulses at cycles 34 and 69, PASS=1 both times.
REQ-037 The bench SHALL cover the MISR build (SCAN_CTRL_MISR_EN): PAT=16'h0000 -> SIG equals the software reference MISR of sixteen 0 bits from seed 16'hFFFF; a non-MISR build compiles without SIG.
